shift_issue_stage: RTL

- ID/EX pipeline register and operand-select stage that feeds the 32-bit barrel shifter in the EX stage.
- Captures decoded shift-class instructions (SLL/SRL/SRA/SLLI/SRLI/SRAI) and maps funct3/funct7 to shift_t.
- Applies EX/MEM and MEM/WB forwarding, then drives Shifter_In, SHAMT and SHIFT_OP.
- Supports pipeline stall (hold) and flush (bubble insertion).

---
 rtl/common_params.sv | 47 ++++
 rtl/shift_fwd_mux.sv | 46 ++++
 rtl/shift_issue_stage.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/common_params.sv
// rtl/common_params.sv - shared widths, shift/forwarding enums and decode helper
//
// Purpose: constants and types shared by the shift issue stage and its
// forwarding selector.
//   BITS / SHW       : datapath width and shift-amount width (SHW = log2(BITS))
//   FUNCT3_SLL/SRX   : funct3 encodings of the shift class
//   shift_t          : shifter operation; 2'b10 is reserved and never driven
//   fwd_sel_t        : which source a forwarded operand came from
package common_params;

  localparam int BITS = 32;
  localparam int SHW  = 5;

  localparam logic [2:0] FUNCT3_SLL = 3'b001;
  localparam logic [2:0] FUNCT3_SRX = 3'b101;

  typedef enum logic [1:0] {
    LL = 2'b00,
    RL = 2'b01,
    RA = 2'b11
  } shift_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  // Unsupported funct3/funct7 combinations fall back to LL; the caller
  // flags them through the legal output.
  function automatic shift_t decode_shift(input logic [2:0] funct3,
                                          input logic       funct7_b5,
                                          output logic      legal);
    shift_t op;
    op    = LL;
    legal = 1'b0;
    if (funct3 == FUNCT3_SLL && !funct7_b5) begin
      op    = LL;
      legal = 1'b1;
    end else if (funct3 == FUNCT3_SRX) begin
      op    = funct7_b5 ? RA : RL;
      legal = 1'b1;
    end
    return op;
  endfunction

endpackage

// File: rtl/shift_fwd_mux.sv
// rtl/shift_fwd_mux.sv - single-operand priority forwarding selector
//
// Purpose: picks the freshest value of one source register.
//   idx          : registered source index
//   rf_data      : registered register-file read
//   mem_regwrite, mem_rd, mem_result : EX/MEM producer
//   wb_regwrite,  wb_rd,  wb_result  : MEM/WB producer
//   data         : selected operand
//   sel          : selected source (for assertions/coverage)
module shift_fwd_mux #(
  parameter int BITS = common_params::BITS
) (
  input  logic [4:0]               idx,
  input  logic [BITS-1:0]          rf_data,
  input  logic                     mem_regwrite,
  input  logic [4:0]               mem_rd,
  input  logic [BITS-1:0]          mem_result,
  input  logic                     wb_regwrite,
  input  logic [4:0]               wb_rd,
  input  logic [BITS-1:0]          wb_result,
  output logic [BITS-1:0]          data,
  output common_params::fwd_sel_t  sel
);
  import common_params::*;

  logic mem_hit;
  logic wb_hit;

  // x0 is hardwired to zero in the register file, so a producer that
  // "writes" x0 must never override the registered read.
  assign mem_hit = mem_regwrite && (mem_rd == idx) && (idx != 5'd0);
  assign wb_hit  = wb_regwrite  && (wb_rd  == idx) && (idx != 5'd0);

  always_comb begin
    data = rf_data;
    sel  = FWD_RF;
    if (mem_hit) begin
      data = mem_result;
      sel  = FWD_MEM;
    end else if (wb_hit) begin
      data = wb_result;
      sel  = FWD_WB;
    end
  end

endmodule

// File: rtl/shift_issue_stage.sv
// rtl/shift_issue_stage.sv - ID/EX register and operand select for the barrel shifter
//
// Purpose: registers a decoded shift-class instruction, forwards its
// operands from EX/MEM and MEM/WB, and presents them to the EX shifter.
//   clk, rst                 : clock, asynchronous active-high reset
//   ID_*                     : decode-stage instruction fields
//   Stall, Flush             : hold / squash (Flush wins)
//   MEM_*, WB_*              : forwarding sources
//   Shifter_In, SHAMT, SHIFT_OP : shifter operands, zeroed when not valid
//   EX_Valid, EX_RD, EX_Illegal : stage status
module shift_issue_stage #(
  parameter int BITS = common_params::BITS,
  parameter int SHW  = common_params::SHW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ID_Valid,
  input  logic [BITS-1:0]        ID_RS1_Data,
  input  logic [BITS-1:0]        ID_RS2_Data,
  input  logic [4:0]             ID_RS1,
  input  logic [4:0]             ID_RS2,
  input  logic [4:0]             ID_RD,
  input  logic [2:0]             ID_Funct3,
  input  logic                   ID_Funct7_b5,
  input  logic                   ID_Use_Imm,
  input  logic [SHW-1:0]         ID_Imm_Shamt,
  input  logic                   Stall,
  input  logic                   Flush,
  input  logic                   MEM_RegWrite,
  input  logic [4:0]             MEM_RD,
  input  logic [BITS-1:0]        MEM_Result,
  input  logic                   WB_RegWrite,
  input  logic [4:0]             WB_RD,
  input  logic [BITS-1:0]        WB_Result,
  output logic [BITS-1:0]        Shifter_In,
  output logic [SHW-1:0]         SHAMT,
  output common_params::shift_t  SHIFT_OP,
  output logic                   EX_Valid,
  output logic [4:0]             EX_RD,
  output logic                   EX_Illegal
);
  import common_params::*;

  logic             valid_q;
  logic             illegal_q;
  shift_t           op_q;
  logic [4:0]       rd_q;
  logic [4:0]       rs1_q;
  logic [4:0]       rs2_q;
  logic [BITS-1:0]  rs1_data_q;
  logic [BITS-1:0]  rs2_data_q;
  logic             use_imm_q;
  logic [SHW-1:0]   imm_shamt_q;

  shift_t           id_op;
  logic             id_legal;

  always_comb begin
    id_legal = 1'b0;
    id_op    = decode_shift(ID_Funct3, ID_Funct7_b5, id_legal);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      illegal_q   <= 1'b0;
      op_q        <= LL;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      use_imm_q   <= 1'b0;
      imm_shamt_q <= '0;
    end else if (Flush) begin
      // Bubble: only the status bits matter, payload is left as-is.
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (!Stall) begin
      valid_q     <= ID_Valid;
      illegal_q   <= ID_Valid & ~id_legal;
      op_q        <= id_op;
      rd_q        <= ID_RD;
      rs1_q       <= ID_RS1;
      rs2_q       <= ID_RS2;
      rs1_data_q  <= ID_RS1_Data;
      rs2_data_q  <= ID_RS2_Data;
      use_imm_q   <= ID_Use_Imm;
      imm_shamt_q <= ID_Imm_Shamt;
    end
  end

  // Forwarding runs on the registered indices every cycle, so a stalled
  // instruction keeps picking up results retiring behind it.
  logic [BITS-1:0] rs1_fwd;
  logic [BITS-1:0] rs2_fwd;
  fwd_sel_t        rs1_sel;
  fwd_sel_t        rs2_sel;

  shift_fwd_mux #(.BITS(BITS)) u_fwd_rs1 (
    .idx          (rs1_q),
    .rf_data      (rs1_data_q),
    .mem_regwrite (MEM_RegWrite),
    .mem_rd       (MEM_RD),
    .mem_result   (MEM_Result),
    .wb_regwrite  (WB_RegWrite),
    .wb_rd        (WB_RD),
    .wb_result    (WB_Result),
    .data         (rs1_fwd),
    .sel          (rs1_sel)
  );

  shift_fwd_mux #(.BITS(BITS)) u_fwd_rs2 (
    .idx          (rs2_q),
    .rf_data      (rs2_data_q),
    .mem_regwrite (MEM_RegWrite),
    .mem_rd       (MEM_RD),
    .mem_result   (MEM_Result),
    .wb_regwrite  (WB_RegWrite),
    .wb_rd        (WB_RD),
    .wb_result    (WB_Result),
    .data         (rs2_fwd),
    .sel          (rs2_sel)
  );

  // Only the low SHW bits of rs2 form the shift amount.
  logic unused_rs2_hi;
  assign unused_rs2_hi = ^rs2_fwd[BITS-1:SHW];

  // Idle stage drives a zero shift of zero so the shifter output is 0.
  assign EX_Valid   = valid_q;
  assign EX_RD      = rd_q;
  assign EX_Illegal = valid_q & illegal_q;
  assign Shifter_In = valid_q ? rs1_fwd : '0;
  assign SHAMT      = !valid_q ? '0 : (use_imm_q ? imm_shamt_q : rs2_fwd[SHW-1:0]);
  assign SHIFT_OP   = valid_q ? op_q : LL;

  a_rs1_x0_not_fwd: assert property (@(posedge clk) disable iff (rst)
    (rs1_q == 5'd0) |-> (rs1_sel == FWD_RF));
  a_rs2_x0_not_fwd: assert property (@(posedge clk) disable iff (rst)
    (rs2_q == 5'd0) |-> (rs2_sel == FWD_RF));
  a_no_reserved_op: assert property (@(posedge clk) disable iff (rst)
    SHIFT_OP != 2'b10);

endmodule
